// File: rtl/dequant_recon_uv.sv
// rtl/dequant_recon_uv.sv - chroma dequantise + 4x4 inverse transform + prediction add
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        begin a reconstruction (honoured in IDLE only)
//   levels       BLOCK_SIZE x 16 signed 16-bit quantised levels, block i at [256i +: 256]
//   pred         BLOCK_SIZE x 16 unsigned 8-bit prediction pixels, block i at [128i +: 128]
//   q_dc, q_ac   unsigned dequant steps for coefficient 0 and coefficients 1..15
//   out          reconstructed pixels, same layout as pred, registered
//   busy         high while an operation is in flight (LOAD .. last HPASS)
//   done         one-cycle pulse when out is complete
module dequant_recon_uv #(
  parameter int BLOCK_SIZE = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [256*BLOCK_SIZE-1:0]   levels,
  input  logic [128*BLOCK_SIZE-1:0]   pred,
  input  logic [15:0]                 q_dc,
  input  logic [15:0]                 q_ac,
  output logic [128*BLOCK_SIZE-1:0]   out,
  output logic                        busy,
  output logic                        done
);

  localparam int BW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [BW-1:0] LAST_BLK = BW'(BLOCK_SIZE - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] DEQ   = 3'd2;
  localparam logic [2:0] VPASS = 3'd3;
  localparam logic [2:0] HPASS = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]    state;
  logic [BW-1:0] blk;
  logic [1:0]    phase;   // column in VPASS, row in HPASS

  logic [256*BLOCK_SIZE-1:0] levels_r;
  logic [128*BLOCK_SIZE-1:0] pred_r;
  logic [15:0]               q_dc_r;
  logic [15:0]               q_ac_r;

  logic signed [31:0] coef [16];
  logic signed [47:0] tmp  [16];

  // Dequantisation. LOAD also acts as block 0's dequant cycle, reading the
  // ports directly while they are being captured, so every block costs a
  // fixed 9 cycles and done lands at 1 + 9*BLOCK_SIZE.
  logic [255:0]       lv_blk;
  logic [15:0]        qd_sel;
  logic [15:0]        qa_sel;
  logic signed [31:0] deq [16];

  always_comb begin
    if (state == LOAD) begin
      lv_blk = levels[255:0];
      qd_sel = q_dc;
      qa_sel = q_ac;
    end else begin
      lv_blk = levels_r[256*blk +: 256];
      qd_sel = q_dc_r;
      qa_sel = q_ac_r;
    end
    // |level*q| < 2^31 for 16-bit signed x 16-bit unsigned, so 32 bits is exact
    for (int k = 0; k < 16; k++) begin
      deq[k] = 32'(signed'(lv_blk[16*k +: 16]))
             * signed'({16'd0, (k == 0) ? qd_sel : qa_sel});
    end
  end

  // One shared butterfly serves both passes; the state selects its inputs.
  function automatic logic signed [63:0] mulk(input logic signed [63:0] x,
                                              input logic signed [63:0] k);
    mulk = (x * k) >>> 16;
  endfunction

  logic signed [63:0] bf_i0, bf_i4, bf_i8, bf_i12;
  logic signed [63:0] bf_a, bf_b, bf_c, bf_d;
  logic signed [63:0] y [4];

  always_comb begin
    if (state == HPASS) begin
      // +4 on the DC term provides the rounding for the final >>>3
      bf_i0  = 64'(tmp[{2'b00, phase}]) + 64'sd4;
      bf_i4  = 64'(tmp[{2'b01, phase}]);
      bf_i8  = 64'(tmp[{2'b10, phase}]);
      bf_i12 = 64'(tmp[{2'b11, phase}]);
    end else begin
      bf_i0  = 64'(coef[{2'b00, phase}]);
      bf_i4  = 64'(coef[{2'b01, phase}]);
      bf_i8  = 64'(coef[{2'b10, phase}]);
      bf_i12 = 64'(coef[{2'b11, phase}]);
    end
    bf_a = bf_i0 + bf_i8;
    bf_b = bf_i0 - bf_i8;
    bf_c = mulk(bf_i4, 64'sd35468) - mulk(bf_i12, 64'sd85627);
    bf_d = mulk(bf_i4, 64'sd85627) + mulk(bf_i12, 64'sd35468);
    y[0] = bf_a + bf_d;
    y[1] = bf_b + bf_c;
    y[2] = bf_b - bf_c;
    y[3] = bf_a - bf_d;
  end

  // Prediction add and saturation for the current HPASS row
  int                 pix_base;
  logic signed [63:0] pix_sum;
  logic [7:0]         pix [4];

  always_comb begin
    pix_base = 128 * int'(blk) + 32 * int'(phase);
    pix_sum  = 64'sd0;
    for (int cc = 0; cc < 4; cc++) begin
      pix_sum = signed'({56'd0, pred_r[pix_base + 8*cc +: 8]}) + (y[cc] >>> 3);
      if (pix_sum < 0)
        pix[cc] = 8'd0;
      else if (pix_sum > 64'sd255)
        pix[cc] = 8'd255;
      else
        pix[cc] = pix_sum[7:0];
    end
  end

  // Control and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      blk   <= '0;
      phase <= 2'd0;
      out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            blk   <= '0;
          end
        end
        LOAD, DEQ: begin
          phase <= 2'd0;
          state <= VPASS;
        end
        VPASS: begin
          phase <= phase + 2'd1;
          if (phase == 2'd3) state <= HPASS;
        end
        HPASS: begin
          for (int cc = 0; cc < 4; cc++) out[pix_base + 8*cc +: 8] <= pix[cc];
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            if (blk == LAST_BLK) begin
              state <= DONE;
            end else begin
              blk   <= blk + 1'b1;
              state <= DEQ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers; only meaningful while busy, so no reset needed
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      levels_r <= levels;
      pred_r   <= pred;
      q_dc_r   <= q_dc;
      q_ac_r   <= q_ac;
    end
    if (state == LOAD || state == DEQ) begin
      for (int k = 0; k < 16; k++) coef[k] <= deq[k];
    end
    if (state == VPASS) begin
      for (int i = 0; i < 4; i++) tmp[{phase, 2'(i)}] <= y[i][47:0];
    end
  end

  assign busy = (state == LOAD) || (state == DEQ) || (state == VPASS) || (state == HPASS);
  assign done = (state == DONE);

endmodule

// File: tb/tb_dequant_recon_uv.sv
// tb/tb_dequant_recon_uv.sv - scoreboard bench for dequant_recon_uv
module tb_dequant_recon_uv;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2047:0] levels;
  logic [1023:0] pred;
  logic [15:0]   q_dc;
  logic [15:0]   q_ac;
  logic [1023:0] out;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  dequant_recon_uv #(.BLOCK_SIZE(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .levels (levels),
    .pred   (pred),
    .q_dc   (q_dc),
    .q_ac   (q_ac),
    .out    (out),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    logic [1023:0] img;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_count = 0;
  int   busy_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_img(input string name, input logic [1023:0] act, input logic [1023:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      for (int p = 0; p < 128; p++) begin
        if (act[8*p +: 8] !== req[8*p +: 8]) begin
          $display("FAIL %s: first bad byte %0d (block %0d) got %0d, expected %0d",
                   name, p, p / 16, act[8*p +: 8], req[8*p +: 8]);
          break;
        end
      end
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_count++;
    if (!rst && done) begin
      done_count++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        check_img("out", out, e.img);
        check_int("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic uniform(input logic [7:0] p, output logic [1023:0] e);
    levels = '0;
    for (int i = 0; i < 128; i++) pred[8*i +: 8] = p;
    e = pred;
  endtask

  task automatic set_level(input int b, input int k, input logic [15:0] v);
    levels[256*b + 16*k +: 16] = v;
  endtask

  task automatic set_pred_blk(input int b, input logic [7:0] p);
    for (int i = 0; i < 16; i++) pred[128*b + 8*i +: 8] = p;
  endtask

  // Called just after a rising edge; that edge's successor samples start
  task automatic issue(input logic [1023:0] e);
    start = 1'b1;
    sb.push_back('{img: e, cyc: cyc + 73});
    step();
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    step();
  endtask

  logic [1023:0] e;
  logic [7:0]    pat [4];
  int            s;

  initial begin
    pat[0] = 8'd103; pat[1] = 8'd101; pat[2] = 8'd99; pat[3] = 8'd98;
    rst = 1'b1; start = 1'b0; levels = '0; pred = '0; q_dc = 16'd0; q_ac = 16'd0;
    repeat (3) step();
    @(negedge clk);
    check_int("reset_busy", busy, 0);
    check_int("reset_done", done, 0);
    check_img("reset_out", out, '0);
    step();
    rst = 1'b0;
    step();

    // All-zero levels: out equals pred; busy count and single done
    uniform(8'h80, e);
    q_dc = 16'd8; q_ac = 16'd8;
    busy_count = 0; done_count = 0;
    issue(e);
    drain();
    check_int("busy_cycles", busy_count, 72);
    check_int("done_pulses", done_count, 1);

    // DC-only block 0; inputs scrambled after LOAD must not matter
    uniform(8'd100, e);
    set_level(0, 0, 16'd1);
    q_dc = 16'd8; q_ac = 16'd8;
    for (int i = 0; i < 16; i++) e[8*i +: 8] = 8'd101;
    issue(e);
    step(); step();
    for (int i = 0; i < 64; i++) levels[32*i +: 32] = $urandom;
    for (int i = 0; i < 32; i++) pred[32*i +: 32] = $urandom;
    q_dc = 16'hffff; q_ac = 16'h1234;
    drain();

    // Saturation high (block 3) and low (block 5)
    uniform(8'd77, e);
    set_pred_blk(3, 8'd250);
    set_pred_blk(5, 8'd50);
    set_level(3, 0, 16'd100);
    set_level(5, 0, -16'sd100);
    q_dc = 16'd8; q_ac = 16'd5;
    e = pred;
    for (int i = 0; i < 16; i++) begin
      e[128*3 + 8*i +: 8] = 8'd255;
      e[128*5 + 8*i +: 8] = 8'd0;
    end
    issue(e);
    drain();

    // AC paths: level[4] exercises the vertical multiply, level[1] the horizontal one
    uniform(8'd100, e);
    set_level(2, 4, 16'd1);
    set_level(6, 1, 16'd1);
    q_dc = 16'd3; q_ac = 16'd16;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        e[128*2 + 8*(4*r + c) +: 8] = pat[r];
        e[128*6 + 8*(4*r + c) +: 8] = pat[c];
      end
    end
    issue(e);
    drain();

    // Start while busy and in the done cycle ignored; the next cycle accepted
    uniform(8'h80, e);
    q_dc = 16'd8; q_ac = 16'd8;
    s = cyc;
    done_count = 0;
    issue(e);
    wait_cyc(s + 9);
    start = 1'b1; step(); start = 1'b0;
    wait_cyc(s + 73);
    start = 1'b1; step();
    sb.push_back('{img: e, cyc: cyc + 73});
    step();
    start = 1'b0;
    drain();
    check_int("restart_done_pulses", done_count, 2);

    // Reset during an operation aborts it with no done
    uniform(8'd200, e);
    s = cyc;
    issue(e);
    sb.delete();
    wait_cyc(s + 30);
    @(negedge clk);
    check_int("midop_busy", busy, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    done_count = 0;
    @(negedge clk);
    check_int("abort_busy", busy, 0);
    check_int("abort_done", done, 0);
    check_img("abort_out", out, '0);
    repeat (100) step();
    check_int("abort_no_done", done_count, 0);

    // rst and start together: rst wins
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_int("rst_start_busy", busy, 0);
    step();
    @(negedge clk);
    check_int("rst_start_busy_later", busy, 0);
    repeat (80) step();
    check_int("rst_start_no_done", done_count, 0);
    check_int("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dequant_recon_uv.md
DEQUANT_RECON_UV -- requirements
Module: dequant_recon_uv

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 8, giving the number of 4x4 chroma blocks per macroblock (4 U + 4 V).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a reconstruction.
REQ-005 SHALL have port levels, input, 2048 bits: block i at [256i+255:256i]; coefficient k (0..15, raster order) at [16k+15:16k] of that slice, signed 16-bit.
REQ-006 SHALL have port pred, input, 1024 bits: block i at [128i+127:128i]; pixel (r,c) at byte 4r+c, unsigned 8-bit.
REQ-007 SHALL have port q_dc, input, 16 bits: unsigned DC dequant step.
REQ-008 SHALL have port q_ac, input, 16 bits: unsigned AC dequant step.
REQ-009 SHALL have port out, output, 1024 bits: reconstructed pixels, same layout as pred, registered.
REQ-010 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when out is complete.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, DEQ, VPASS, HPASS, DONE.
REQ-013 IDLE: start=1 -> LOAD; LOAD captures levels, pred, q_dc and q_ac into internal registers and sets block counter b=0.
REQ-014 Inputs SHALL be sampled only in LOAD; input changes after that cycle SHALL have no effect on the current operation.
REQ-015 DEQ (1 cycle): coef[0]=levels[b][0]*q_dc; coef[k]=levels[b][k]*q_ac for k=1..15; signed result, 32-bit wide; -> VPASS.
REQ-016 VPASS (4 cycles, column j=0..3 per cycle): a=c0+c8, b=c0-c8, c=M(c4,35468)-M(c12,85627), d=M(c4,85627)+M(c12,35468); tmp[4j..4j+3]={a+d, b+c, b-c, a-d}. Here cN=coef[j+N], and M(x,k) is (x*k)>>>16 with arithmetic shift. -> HPASS.
REQ-017 HPASS (4 cycles, row r=0..3 per cycle): dc=tmp[r]+4; a=dc+tmp[8+r], b=dc-tmp[8+r], c=M(tmp[4+r],35468)-M(tmp[12+r],85627), d=M(tmp[4+r],85627)+M(tmp[12+r],35468); pixel(r,0..3)=clip255(pred+({a+d,b+c,b-c,a-d}>>>3)) written into out block b.
REQ-018 clip255 SHALL saturate to 0 below 0 and to 255 above 255; intermediate arithmetic SHALL be at least 32-bit signed with no wrap.
REQ-019 After HPASS row 3: if b<BLOCK_SIZE-1, b increments and the FSM goes to DEQ; otherwise it goes to DONE.
REQ-020 DONE SHALL assert done for exactly 1 cycle, then return to IDLE.
REQ-021 Latency is fixed at 9 cycles per block: with start sampled at edge 0, done SHALL be high in cycle 1+9*BLOCK_SIZE (=73 for BLOCK_SIZE 8), independent of data.
REQ-022 busy SHALL be 1 in LOAD through the last HPASS cycle and 0 in IDLE and DONE.
REQ-023 start SHALL be ignored when the FSM is not in IDLE; there is no queueing.
REQ-024 out blocks not yet rewritten SHALL hold their previous values; out SHALL be valid from the done cycle until the next LOAD.
REQ-025 start is accepted in IDLE only, so a start in the done cycle SHALL be ignored; a start in the following cycle SHALL be accepted.

Reset
REQ-026 rst=1 at any edge SHALL force IDLE, b=0, busy=0, done=0 and out=0, overriding start and any in-flight operation.
REQ-027 An operation aborted by rst SHALL produce no done pulse.

Verification
REQ-028 All levels 0, pred all 0x80, q_dc=q_ac=8 -> out all 0x80; done exactly 73 cycles after start; busy high for 72 cycles.
REQ-029 Block 0 level[0]=1, q_dc=8, all other levels 0, pred all 100 -> block 0 pixels 101, blocks 1..7 pixels 100.
REQ-030 Block 3 level[0]=100, q_dc=8, pred 250 -> block 3 pixels 255. Block 5 level[0]=-100, pred 50 -> block 5 pixels 0. Both are clip checks.
REQ-031 A second start pulsed at cycles 10 and 73 is ignored; a start at cycle 74 is accepted and done follows 73 cycles later.
REQ-032 rst asserted at cycle 30 of an operation -> next cycle busy=0, done=0, out=0; done never pulses. rst and start together -> rst wins, FSM stays in IDLE.
